// File: rtl/nibble_serial_adder_pkg.sv
// rtl/nibble_serial_adder_pkg.sv - shared constants and state encoding for nibble_serial_adder
//
// Contents:
//   NIBBLE_W : width of one adder slice (4 bits)
//   state_e  : FSM encoding (ST_IDLE, ST_RUN, ST_DONE)
package nibble_serial_adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_rca_4.sv
// rtl/nibble_serial_adder_rca_4.sv - 4-bit ripple-carry adder slice
//
// Ports:
//   a, b  : input  [3:0] addends
//   cin   : input        carry in
//   sum   : output [3:0] a + b + cin (mod 16)
//   cout  : output       carry out of bit 3
module rca_4
    import nibble_serial_adder_pkg::*;
(
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout,
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin
);

    logic [NIBBLE_W:0] carry;

    // Explicit ripple chain so the slice stays a true ripple adder.
    always_comb begin
        carry[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
        end
        cout = carry[NIBBLE_W];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle WIDTH-bit adder using one 4-bit ripple slice
//
// Operands are accepted over in_valid/in_ready, summed one nibble per clock
// (LS nibble first, carry held in a register), and returned over
// out_valid/out_ready. Optional subtract mode under NIBBLE_SERIAL_ADDER_SUB_EN.
//
// Parameters:
//   WIDTH     : operand/sum width, multiple of 4, >= 4
// Ports:
//   clk       : input         rising-edge clock
//   rst       : input         asynchronous active-high reset
//   in_valid  : input         operand pair presented
//   in_ready  : output        operands accepted (IDLE only, low during reset)
//   a, b      : input  WIDTH  operands
//   cin       : input         carry into nibble 0
//   sub       : input         (NIBBLE_SERIAL_ADDER_SUB_EN only) 1 = a - b
//   out_valid : output        result available (DONE only)
//   out_ready : input         consumer takes result
//   sum       : output WIDTH  result
//   cout      : output        carry out of top nibble (no-borrow when subtracting)
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;

    logic               accept;
    logic               last_nib;
    logic               b_inv;
    logic               carry_load;
    int unsigned        bit_base;

    logic [NIBBLE_W-1:0] rca_a;
    logic [NIBBLE_W-1:0] rca_b;
    logic [NIBBLE_W-1:0] rca_sum;
    logic                rca_cout;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    logic sub_q, sub_d;

    // Subtract = a + ~b + 1: invert B per nibble and force the initial carry.
    assign b_inv      = sub_q;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_inv      = 1'b0;
    assign carry_load = cin;
`endif

    assign accept   = in_valid && in_ready;
    assign last_nib = (idx_q == LAST_IDX);
    assign bit_base = NIBBLE_W * int'(idx_q);

    // ------------------------------------------------------------------
    // Single shared adder slice
    // ------------------------------------------------------------------
    always_comb begin
        rca_a = a_q[bit_base +: NIBBLE_W];
        rca_b = b_q[bit_base +: NIBBLE_W] ^ {NIBBLE_W{b_inv}};
    end

    rca_4 u_rca_4 (
        .sum  (rca_sum),
        .cout (rca_cout),
        .a    (rca_a),
        .b    (rca_b),
        .cin  (carry_q)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_RUN;
            ST_RUN:  if (last_nib)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        // in_ready is gated by rst so it reads 0 for the whole reset pulse.
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
        sum       = sum_q;
        cout      = cout_q;
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = carry_load;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
`endif
                end
            end
            ST_RUN: begin
                sum_d[bit_base +: NIBBLE_W] = rca_sum;
                carry_d = rca_cout;
                idx_d   = idx_q + IDX_W'(1);
                if (last_nib) begin
                    cout_d = rca_cout;
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

endmodule
